// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer: serialises CPU byte/half/word load-store requests into
// single-byte accesses on a plain 8-bit synchronous RAM (little-endian), and
// reassembles load data with sign or zero extension.
// Optional build macro: LSU_MISALIGN_CHECK_EN. When it is defined, misaligned
// half/word accesses and size 11 are rejected with resp_err. When it is not
// defined, no checking is done and size 11 behaves as a word access.
//
// Handshakes: a transfer on req_* or resp_* happens on a rising edge where
// valid and ready are both high. A valid that has been raised stays up until
// that edge, and its payload stays stable while it waits. resp_rdata and
// resp_err are stable for as long as resp_valid is high.
module lsu_byte_sequencer #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [WIDTH-1:0]      req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  // The state register is the debug view of the sequencer.
  typedef enum logic [1:0] {IDLE, XFER, TAIL, RESP} state_t;

  state_t           state;
  logic             we_q;
  logic             uns_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] asm_q;
  logic [1:0]       cnt;

  logic             accept;
  logic             req_err;
  logic [1:0]       last_idx;
  logic [1:0]       cnt_next;
  logic [1:0]       cnt_prev;
  logic [WIDTH-1:0] tail_word;
  logic [WIDTH-1:0] ext_word;

  // Address bits above the RAM range are ignored.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^req_addr[WIDTH-1:ADDR_WIDTH];

  assign accept   = req_valid & req_ready;
  assign cnt_next = cnt + 2'd1;
  assign cnt_prev = cnt - 2'd1;

  // Classify an incoming request as rejected (only when checking is built in).
  always_comb begin
    req_err = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
`endif
  end

  // Index of the last byte of the latched access (size 11 counts as a word).
  always_comb begin
    case (size_q)
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

  // Merge the final read byte, then sign- or zero-extend to the full width.
  always_comb begin
    tail_word = asm_q;
    tail_word[{last_idx, 3'b000} +: 8] = mem_rdata;
    case (size_q)
      2'b00:   ext_word = uns_q ? {{(WIDTH-8){1'b0}}, tail_word[7:0]}
                                : {{(WIDTH-8){tail_word[7]}}, tail_word[7:0]};
      2'b01:   ext_word = uns_q ? {{(WIDTH-16){1'b0}}, tail_word[15:0]}
                                : {{(WIDTH-16){tail_word[15]}}, tail_word[15:0]};
      default: ext_word = tail_word;
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cnt        <= 2'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      wdata_q    <= '0;
      asm_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            wdata_q    <= req_wdata;
            asm_q      <= '0;
            resp_rdata <= '0;
            cnt        <= 2'd0;
            req_ready  <= 1'b0;
            if (req_err) begin
              // Rejected: no RAM access at all.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= XFER;
              resp_err  <= 1'b0;
              mem_addr  <= req_addr[ADDR_WIDTH-1:0];
              mem_we    <= req_we;
              mem_wdata <= req_wdata[7:0];
            end
          end
        end

        XFER: begin
          // Read data for the previous address arrives one cycle late.
          if (!we_q && (cnt != 2'd0)) begin
            asm_q[{cnt_prev, 3'b000} +: 8] <= mem_rdata;
          end
          if (cnt == last_idx) begin
            mem_we <= 1'b0;
            if (we_q) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= TAIL;
            end
          end else begin
            cnt       <= cnt_next;
            mem_addr  <= mem_addr + ADDR_WIDTH'(1);
            mem_wdata <= wdata_q[{cnt_next, 3'b000} +: 8];
          end
        end

        TAIL: begin
          resp_rdata <= ext_word;
          resp_valid <= 1'b1;
          state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// tb_lsu_byte_sequencer: scoreboard bench for lsu_byte_sequencer with a
// behavioural 8-bit synchronous RAM and a shadow memory model.
module tb_lsu_byte_sequencer;

  localparam int W  = 32;
  localparam int AW = 17;
  localparam int RAM_SIZE = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [W-1:0]  req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [W-1:0]  resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  lsu_byte_sequencer #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- RAM model ----------------
  logic [7:0] ram [0:RAM_SIZE-1];
  logic [7:0] ram_q = 8'h00;
  logic       ram_clr = 1'b1;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < RAM_SIZE; i++) ram[i] <= 8'h00;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      ram_q <= ram[mem_addr];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]      shadow [0:RAM_SIZE-1];
  logic [W-1:0]    exp_q[$];
  logic [0:0]      err_q[$];
  logic [31:0]     lat_q[$];
  logic [AW+7:0]   wr_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] extend(input logic [1:0] size, input logic uns, input logic [W-1:0] v);
    case (size)
      2'b00:   return uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2'b01:   return uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  function automatic logic is_err(input logic [1:0] size, input logic [W-1:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    return (size == 2'b11) || (size == 2'b10 && addr[1:0] != 2'b00) ||
           (size == 2'b01 && addr[0]);
`else
    return 1'b0 & ^{size, addr};
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        check("unexpected_write", {7'h0, mem_addr, mem_wdata}, '1);
      end else begin
        check("wr_addr", W'(mem_addr), W'(wr_q[0][AW+7:8]));
        check("wr_byte", W'(mem_wdata), W'(wr_q[0][7:0]));
        void'(wr_q.pop_front());
      end
    end
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (req_valid && req_ready) acc_cyc = cyc + 1;
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", resp_rdata, '1);
        end else begin
          if (!prev_valid) check("latency", W'(cyc - acc_cyc + 1), lat_q[0]);
          check("hold_rdata", resp_rdata, exp_q[0]);
          check("hold_err", W'(resp_err), W'(err_q[0]));
          check("busy_req_ready", W'(req_ready), '0);
          if (resp_ready) begin
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_valid <= resp_valid && !resp_ready;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic we, input logic [1:0] size, input logic uns,
                              input logic [W-1:0] addr, input logic [W-1:0] wdata);
    logic got = 1'b0;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", '0, '1);
      req_valid = 1'b0;
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [W-1:0] addr, input logic [W-1:0] wdata, input int hold);
    int n;
    logic [AW-1:0] a;
    logic [W-1:0] v;
    logic seen = 1'b0;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    if (is_err(size, addr)) begin
      exp_q.push_back('0); err_q.push_back(1'b1); lat_q.push_back(1);
    end else if (we) begin
      for (int i = 0; i < n; i++) begin
        a = addr[AW-1:0] + AW'(i);
        wr_q.push_back({a, wdata[8*i +: 8]});
        shadow[a] = wdata[8*i +: 8];
      end
      exp_q.push_back('0); err_q.push_back(1'b0); lat_q.push_back(32'(n + 1));
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) begin
        a = addr[AW-1:0] + AW'(i);
        v[8*i +: 8] = shadow[a];
      end
      exp_q.push_back(extend(size, uns, v)); err_q.push_back(1'b0); lat_q.push_back(32'(n + 2));
    end
    drive_accept(we, size, uns, addr, wdata);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      check("resp_timeout", '0, '1);
      void'(exp_q.pop_back()); void'(err_q.pop_back()); void'(lat_q.pop_back());
    end else begin
      @(posedge clk);
      repeat (hold) @(posedge clk);
      #1 resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < RAM_SIZE; i++) shadow[i] = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 ram_clr = 1'b0;
    @(negedge clk);
    check("rst_req_ready", W'(req_ready), W'(1));
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_err", W'(resp_err), '0);
    check("rst_resp_rdata", resp_rdata, '0);
    check("rst_mem_we", W'(mem_we), '0);
    check("rst_mem_addr", W'(mem_addr), '0);
    check("rst_mem_wdata", W'(mem_wdata), '0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed cases.
    send(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0);
    send(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 0);
    send(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1);
    send(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 0);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5);
    send(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 0);
    send(1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 0);
    send(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 2);

    // Top-of-RAM wrap with upper address bits ignored.
    send(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 0);
    send(1'b0, 2'b10, 1'b0, 32'h0001_FFFE, 32'h0, 0);
    send(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0, 0);

    // Reset during the second byte of a word store: only two bytes land.
    wr_q.push_back({AW'(17'h200), 8'h44});
    wr_q.push_back({AW'(17'h201), 8'h33});
    shadow[17'h200] = 8'h44;
    shadow[17'h201] = 8'h33;
    drive_accept(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_mem_we", W'(mem_we), '0);
    check("abort_req_ready", W'(req_ready), W'(1));
    check("abort_resp_valid", W'(resp_valid), '0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_resp", W'(resp_valid), '0);
    end
    @(posedge clk); #1;
    send(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 0);

    // Random mix in a small window.
    for (int t = 0; t < 30; t++) begin
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           32'h0000_0300 + 32'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("left_expected", W'(exp_q.size()), '0);
    check("left_writes", W'(wr_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
